// File: rtl/multi_channel_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer family.
// State encodings are fixed so other button logic can decode them directly.
package multi_channel_debouncer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_PRESS_CHK = 2'b01,
      ST_HELD      = 2'b10,
      ST_REL_CHK   = 2'b11
   } deb_state_e;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic long_p;
      logic rpt;
   } deb_out_t;

   // Bits needed to hold any value in 0..max_val (never less than one).
   function automatic int cnt_width(input int max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/multi_channel_debouncer_channel.sv
// One button channel: 2-flop synchroniser, qualification FSM, stability and
// hold counters, with every output registered.
module multi_channel_debouncer_channel
   import multi_channel_debouncer_pkg::*;
#(
   parameter int STABLE_SAMPLES = 3,
   parameter int HOLD_SAMPLES   = 100,
   parameter int REPEAT_SAMPLES = 20,
   parameter int REPEAT_EN      = 1,
   parameter int ACTIVE_LOW     = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int STAB_W = cnt_width(STABLE_SAMPLES);
   localparam int HOLD_W = cnt_width(HOLD_SAMPLES + REPEAT_SAMPLES);
   localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_SAMPLES);
   localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(HOLD_SAMPLES);
   localparam logic [HOLD_W-1:0] HOLD_RPT  = HOLD_W'(HOLD_SAMPLES + REPEAT_SAMPLES);

   logic              sync1_q, sync1_d;
   logic              sync2_q;
   logic              s;
   deb_state_e        state_q, state_d;
   logic [STAB_W-1:0] stab_q, stab_d, stab_inc;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   deb_out_t          out_q, out_d;

   assign s = sync2_q;

   always_comb begin
      sync1_d  = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
      state_d  = state_q;
      stab_d   = stab_q;
      hold_d   = hold_q;
      stab_inc = stab_q + 1'b1;
      hold_inc = hold_q + 1'b1;
      out_d       = '0;
      out_d.level = out_q.level;

      // A changed input always beats a coincident tick: the bounce path is tested first.
      unique case (state_q)
         ST_IDLE: begin
            if (s) begin
               state_d = ST_PRESS_CHK;
               stab_d  = '0;
            end
         end
         ST_PRESS_CHK: begin
            if (!s) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (stab_inc == STAB_DONE) begin
                  state_d     = ST_HELD;
                  out_d.level = 1'b1;
                  out_d.press = 1'b1;
                  hold_d      = '0;
               end else begin
                  stab_d = stab_inc;
               end
            end
         end
         ST_HELD: begin
            if (!s) begin
               state_d = ST_REL_CHK;
               stab_d  = '0;
            end else if (tick) begin
               if (hold_inc == HOLD_LONG) begin
                  out_d.long_p = 1'b1;
               end
               if (REPEAT_EN != 0) begin
                  // Reload to HOLD_LONG so repeats run forever without re-firing long.
                  if (hold_inc == HOLD_RPT) begin
                     out_d.rpt = 1'b1;
                     hold_d    = HOLD_LONG;
                  end else begin
                     hold_d = hold_inc;
                  end
               end else if (hold_q != HOLD_LONG) begin
                  hold_d = hold_inc;
               end
            end
         end
         ST_REL_CHK: begin
            if (s) begin
               state_d = ST_HELD;
            end else if (tick) begin
               if (stab_inc == STAB_DONE) begin
                  state_d     = ST_IDLE;
                  out_d.level = 1'b0;
                  out_d.rel   = 1'b1;
                  hold_d      = '0;
               end else begin
                  stab_d = stab_inc;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_IDLE;
         stab_q  <= '0;
         hold_q  <= '0;
         out_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync1_q;
         state_q <= state_d;
         stab_q  <= stab_d;
         hold_q  <= hold_d;
         out_q   <= out_d;
      end
   end

   assign level         = out_q.level;
   assign press_pulse   = out_q.press;
   assign release_pulse = out_q.rel;
   assign long_pulse    = out_q.long_p;
   assign repeat_pulse  = out_q.rpt;

endmodule

// File: rtl/multi_channel_debouncer.sv
// N-channel push-button debouncer: one shared sample-tick prescaler feeding
// an independent qualification channel per button.
module multi_channel_debouncer
   import multi_channel_debouncer_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int SAMPLE_CYCLES  = 500000,
   parameter int STABLE_SAMPLES = 3,
   parameter int HOLD_SAMPLES   = 100,
   parameter int REPEAT_SAMPLES = 20,
   parameter int REPEAT_EN      = 1,
   parameter int ACTIVE_LOW     = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_pulse,
   output logic [N_CH-1:0] repeat_pulse
);

   localparam int PRE_W = cnt_width(SAMPLE_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_CYCLES - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;

   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      multi_channel_debouncer_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .HOLD_SAMPLES   (HOLD_SAMPLES),
         .REPEAT_SAMPLES (REPEAT_SAMPLES),
         .REPEAT_EN      (REPEAT_EN),
         .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .tick          (tick),
         .btn_raw       (btn_raw[gi]),
         .level         (level[gi]),
         .press_pulse   (press_pulse[gi]),
         .release_pulse (release_pulse[gi]),
         .long_pulse    (long_pulse[gi]),
         .repeat_pulse  (repeat_pulse[gi])
      );
   end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Bench: two debouncers (active-high and active-low with inverted stimulus)
// checked cycle by cycle against a scoreboard of expected pulse edges.
module tb_multi_channel_debouncer;

   localparam int N_CH   = 2;
   localparam int SC     = 4;
   localparam int STABLE = 3;
   localparam int HOLD   = 5;
   localparam int REP    = 2;
   localparam int LAT    = 3;   // drive-to-FSM-sample delay: 2 sync flops + 1
   localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2, K_REP = 3;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [N_CH-1:0] btn   = '0;
   logic [N_CH-1:0] btn_n;
   logic [N_CH-1:0] level [2];
   logic [N_CH-1:0] press [2];
   logic [N_CH-1:0] rel   [2];
   logic [N_CH-1:0] lng   [2];
   logic [N_CH-1:0] rpt   [2];

   assign btn_n = ~btn;

   multi_channel_debouncer #(
      .N_CH(N_CH), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(STABLE),
      .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP), .REPEAT_EN(1), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset(rst_n), .btn_raw(btn),
      .level(level[0]), .press_pulse(press[0]), .release_pulse(rel[0]),
      .long_pulse(lng[0]), .repeat_pulse(rpt[0])
   );

   multi_channel_debouncer #(
      .N_CH(N_CH), .SAMPLE_CYCLES(SC), .STABLE_SAMPLES(STABLE),
      .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP), .REPEAT_EN(1), .ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .reset(rst_n), .btn_raw(btn_n),
      .level(level[1]), .press_pulse(press[1]), .release_pulse(rel[1]),
      .long_pulse(lng[1]), .repeat_pulse(rpt[1])
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges since reset was released
   int cyc = 0;
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int exp_q [8][$];        // index ch*4+kind, entries are edge numbers
   int lvl_exp [2];
   int obs [2][4];
   int checks = 0;
   int passed = 0;

   typedef struct {
      string       name;
      logic [1:0]  mask;
      int          phase;
      int          dur;
      int          glitch;
      bit          bounce;
      int          n_press;
      int          n_rel;
      int          n_long;
      int          n_rep;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, req, cyc);
   endtask

   function automatic string kname(input int k);
      case (k)
         K_PRESS: return "press";
         K_REL:   return "release";
         K_LONG:  return "long";
         default: return "repeat";
      endcase
   endfunction

   function automatic logic [1:0] pulse_of(input int inst, input int k);
      case (k)
         K_PRESS: return press[inst];
         K_REL:   return rel[inst];
         K_LONG:  return lng[inst];
         default: return rpt[inst];
      endcase
   endfunction

   function automatic int next_tick(input int e);
      return ((e + SC - 1) / SC) * SC;
   endfunction

   // Push every edge at which a pulse is due for a press driven at c0 and
   // released at c1 (no glitch landing on a tick edge).
   task automatic schedule(input logic [1:0] mask, input int c0, input int c1, output int r_edge);
      int p;
      p      = next_tick(c0 + LAT + 1) + (STABLE - 1) * SC;
      r_edge = next_tick(c1 + LAT + 1) + (STABLE - 1) * SC;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (mask[ch]) begin
            exp_q[ch*4 + K_PRESS].push_back(p);
            for (int k = 1; p + k * SC <= c1 + LAT - 1; k++) begin
               if (k == HOLD) exp_q[ch*4 + K_LONG].push_back(p + k * SC);
               if (k >= HOLD + REP && (k - HOLD - REP) % REP == 0)
                  exp_q[ch*4 + K_REP].push_back(p + k * SC);
            end
            exp_q[ch*4 + K_REL].push_back(r_edge);
         end
      end
   endtask

   task automatic monitor_cycle();
      logic [1:0] pv;
      logic       got;
      logic       due;
      int         idx;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++)
            check($sformatf("reset_outputs dut%0d", i),
                  int'({level[i], press[i], rel[i], lng[i], rpt[i]}), 0);
         return;
      end
      for (int ch = 0; ch < N_CH; ch++) begin
         for (int k = 0; k < 4; k++) begin
            idx = ch * 4 + k;
            due = 1'b0;
            if (exp_q[idx].size() > 0) due = (exp_q[idx][0] == cyc);
            for (int i = 0; i < 2; i++) begin
               pv  = pulse_of(i, k);
               got = pv[ch];
               if (got) obs[i][k]++;
               if (got || due)
                  check($sformatf("%s ch%0d dut%0d", kname(k), ch, i), int'(got), int'(due));
            end
            if (due) begin
               void'(exp_q[idx].pop_front());
               if (k == K_PRESS) lvl_exp[ch] = 1;
               if (k == K_REL)   lvl_exp[ch] = 0;
            end
         end
         for (int i = 0; i < 2; i++) begin
            pv = level[i];
            check($sformatf("level ch%0d dut%0d", ch, i), int'(pv[ch]), lvl_exp[ch]);
         end
      end
   endtask

   always @(negedge clk) monitor_cycle();

   // Assert reset mid-cycle and check outputs clear before any clock edge.
   task automatic do_reset(input int ncyc);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      for (int j = 0; j < 8; j++) exp_q[j].delete();
      lvl_exp[0] = 0;
      lvl_exp[1] = 0;
      #1;
      for (int i = 0; i < 2; i++)
         check($sformatf("async_reset dut%0d", i),
               int'({level[i], press[i], rel[i], lng[i], rpt[i]}), 0);
      repeat (ncyc) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int c0;
      int r_edge;
      int snap [2][4];
      int req [4];
      while (cyc % SC != v.phase) @(negedge clk);
      #1;
      c0 = cyc;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++) snap[i][k] = obs[i][k];
      if (v.bounce) begin
         for (int t = 0; t < v.dur; t++) begin
            btn = ((t / 3) % 2 == 0) ? v.mask : 2'b00;
            @(negedge clk);
            #1;
         end
         btn = 2'b00;
         repeat (20) @(negedge clk);
      end else begin
         btn = v.mask;
         schedule(v.mask, c0, c0 + v.dur, r_edge);
         for (int t = 1; t <= v.dur; t++) begin
            @(negedge clk);
            #1;
            if (v.glitch != 0 && t == v.glitch)     btn = 2'b00;
            if (v.glitch != 0 && t == v.glitch + 2) btn = v.mask;
         end
         btn = 2'b00;
         while (cyc < r_edge + 8) @(negedge clk);
      end
      req[K_PRESS] = v.n_press;
      req[K_REL]   = v.n_rel;
      req[K_LONG]  = v.n_long;
      req[K_REP]   = v.n_rep;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++)
            check($sformatf("%s count %s dut%0d", v.name, kname(k), i),
                  obs[i][k] - snap[i][k], req[k]);
      $display("vec %s: press=%0d release=%0d long=%0d repeat=%0d",
               v.name, obs[0][K_PRESS] - snap[0][K_PRESS], obs[0][K_REL] - snap[0][K_REL],
               obs[0][K_LONG] - snap[0][K_LONG], obs[0][K_REP] - snap[0][K_REP]);
   endtask

   initial begin
      int r_edge;
      vecs[0] = '{"clean_ch0_hold12", 2'b01, 0, 60, 0,  1'b0, 1, 1, 1, 3};
      vecs[1] = '{"short_ch1",        2'b10, 1, 20, 0,  1'b0, 1, 1, 0, 0};
      vecs[2] = '{"both_same_cycle",  2'b11, 3, 40, 0,  1'b0, 2, 2, 2, 2};
      vecs[3] = '{"bounce_ch0",       2'b01, 2, 40, 0,  1'b1, 0, 0, 0, 0};
      vecs[4] = '{"glitch_ch0",       2'b01, 0, 30, 22, 1'b0, 1, 1, 1, 0};
      vecs[5] = '{"min_hold_ch0",     2'b01, 2, 14, 0,  1'b0, 1, 1, 0, 0};
      lvl_exp[0] = 0;
      lvl_exp[1] = 0;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++) obs[i][k] = 0;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[n]) run_vec(vecs[n]);

      // Reset inside PRESS_CHK, then inside HELD, with the button kept down.
      while (cyc % SC != 0) @(negedge clk);
      #1;
      btn = 2'b01;
      repeat (6) @(negedge clk);
      do_reset(3);
      exp_q[K_PRESS].push_back(next_tick(LAT + 1) + (STABLE - 1) * SC);
      while (cyc < 17) @(negedge clk);
      do_reset(3);
      schedule(2'b01, 0, 30, r_edge);
      while (cyc < 30) @(negedge clk);
      #1;
      btn = 2'b00;
      while (cyc < r_edge + 8) @(negedge clk);
      $display("seq reset_reacquire: press=%0d release=%0d", obs[0][K_PRESS], obs[0][K_REL]);

      for (int j = 0; j < 8; j++)
         check($sformatf("scoreboard_drained q%0d", j), exp_q[j].size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
